powlib_ipseqgen: RTL and testbench

Sequence generator that sits directly upstream of the IP RAM on the powlib bus. It turns one command (op, start address, beat count) into a stream of single-beat powlib write or read requests with incrementing addresses, and consumes the matching read responses. It reports completion with a one-cycle pulse and feeds the RAM's input FIFO (wraddr/wrdata/wrvld/wrrdy).

---
 rtl/powlib_ipseqgen_pkg.sv | 8 +
 rtl/powlib_ipseqgen_packintr.sv | 14 +
 rtl/powlib_ipseqgen.sv | 153 +++++++++++++++
 tb/tb_powlib_ipseqgen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/powlib_ipseqgen_pkg.sv
// Shared powlib bus constants used by the IP sequence generator and its packer.
// Values mirror the powlib bus word layout: op field width and op codes.
package powlib_ipseqgen_pkg;
    localparam int POWLIB_BW  = 8;
    localparam int POWLIB_OPW = 4;
    localparam logic [POWLIB_OPW-1:0] POWLIB_OP_WRITE = 4'h0;
    localparam logic [POWLIB_OPW-1:0] POWLIB_OP_READ  = 4'h1;
endpackage

// File: rtl/powlib_ipseqgen_packintr.sv
// Packs data, byte-enable and op into one powlib bus word.
// Layout, MSB first: {op, be, data}.
module powlib_ippackintr0
    import powlib_ipseqgen_pkg::*;
#(
    parameter int B_BPD = 4
) (
    input  logic [POWLIB_BW*B_BPD-1:0]                  data,
    input  logic [B_BPD-1:0]                            be,
    input  logic [POWLIB_OPW-1:0]                       op,
    output logic [POWLIB_OPW+B_BPD+POWLIB_BW*B_BPD-1:0] word
);
    assign word = {op, be, data};
endmodule

// File: rtl/powlib_ipseqgen.sv
// Turns one (op, addr, len) command into a stream of single-beat powlib requests
// with incrementing addresses, counts read responses and pulses done at the end.
module powlib_ipseqgen
    import powlib_ipseqgen_pkg::*;
#(
    parameter          ID    = "IPSEQGEN",
    parameter int      EDBG  = 0,
    parameter int      B_BPD = 4,
    parameter int      B_AW  = POWLIB_BW*B_BPD,
    parameter int      LENW  = 8,
    localparam int     B_DW  = POWLIB_BW*B_BPD,
    localparam int     B_WW  = POWLIB_OPW+B_BPD+B_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [POWLIB_OPW-1:0] cmdop,
    input  logic [B_AW-1:0]       cmdaddr,
    input  logic [LENW-1:0]       cmdlen,
    input  logic [B_DW-1:0]       cmddata,
    input  logic                  cmdvld,
    output logic                  cmdrdy,
    output logic [B_AW-1:0]       wraddr,
    output logic [B_WW-1:0]       wrdata,
    output logic                  wrvld,
    input  logic                  wrrdy,
    input  logic [B_AW-1:0]       rdaddr,
    input  logic [B_WW-1:0]       rddata,
    input  logic                  rdvld,
    output logic                  rdrdy,
    output logic                  busy,
    output logic                  done,
    output logic                  stray
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // wrvld/wraddr/wrdata never change while wrvld is high and wrrdy is low.
    logic [1:0]            state;
    logic [POWLIB_OPW-1:0] op_q;
    logic [B_DW-1:0]       data_q;
    logic [B_BPD-1:0]      be_q;
    logic [LENW-1:0]       len_q;
    logic [LENW:0]         beat_cnt;
    logic [LENW:0]         rsp_cnt;

    logic [LENW:0]         total;
    logic [LENW:0]         rsp_next;
    logic                  rsp_take;
    logic                  last_beat;
    logic                  is_write;
    logic [B_AW-1:0]       rd_field;
    logic [B_DW-1:0]       data_step;

    assign rdrdy = 1'b1;

    always_comb begin
        total     = {1'b0, len_q} + (LENW+1)'(1);
        rsp_take  = rdvld && (state == S_ISSUE || state == S_WAIT) && (rsp_cnt != total);
        rsp_next  = rsp_cnt + (LENW+1)'(rsp_take);
        last_beat = (beat_cnt == {1'b0, len_q});
        is_write  = (op_q == POWLIB_OP_WRITE);
        // Reads carry the return address in the low B_AW bits; writes carry a data count.
        rd_field  = data_q[B_AW-1:0] + B_AW'(B_BPD);
        data_step = is_write ? data_q + B_DW'(1) : B_DW'(rd_field);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            data_q   <= '0;
            be_q     <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            rsp_cnt  <= '0;
            wraddr   <= '0;
            wrvld    <= 1'b0;
            cmdrdy   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            stray    <= 1'b0;
        end else begin
            rsp_cnt <= rsp_next;
            case (state)
                S_IDLE: begin
                    if (rdvld) stray <= 1'b1;
                    if (cmdvld) begin
                        op_q     <= cmdop;
                        wraddr   <= cmdaddr;
                        len_q    <= cmdlen;
                        be_q     <= '1;
                        data_q   <= (cmdop == POWLIB_OP_WRITE) ? cmddata : B_DW'(cmddata[B_AW-1:0]);
                        beat_cnt <= '0;
                        rsp_cnt  <= '0;
                        wrvld    <= 1'b1;
                        cmdrdy   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (wrrdy) begin
                        if (last_beat) begin
                            wrvld <= 1'b0;
                            // A read whose responses all arrived early skips WAIT.
                            if (is_write || rsp_next == total) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + (LENW+1)'(1);
                            wraddr   <= wraddr + B_AW'(B_BPD);
                            data_q   <= data_step;
                        end
                    end
                end
                S_WAIT: begin
                    if (rsp_next == total) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    cmdrdy <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    powlib_ippackintr0 #(.B_BPD(B_BPD)) u_pack (
        .data (data_q),
        .be   (be_q),
        .op   (op_q),
        .word (wrdata)
    );

    // Response payloads are not needed; only their arrival is counted.
    logic unused_rsp;
    assign unused_rsp = ^{rdaddr, rddata};

    if (EDBG != 0 && $bits(ID) > 0) begin : g_dbg
        logic [1:0] unused_dbg_state;
        assign unused_dbg_state = state;
    end
endmodule

// File: tb/tb_powlib_ipseqgen.sv
// Bench for powlib_ipseqgen: directed and random commands checked against a
// beat/response reference model built from the command fields.
module tb_powlib_ipseqgen;
    localparam int BPD  = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WW   = 40;
    localparam int LENW = 8;
    localparam logic [3:0] OP_W = 4'h0;
    localparam logic [3:0] OP_R = 4'h1;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      cmdop;
    logic [AW-1:0]   cmdaddr;
    logic [LENW-1:0] cmdlen;
    logic [DW-1:0]   cmddata;
    logic            cmdvld;
    logic            cmdrdy;
    logic [AW-1:0]   wraddr;
    logic [WW-1:0]   wrdata;
    logic            wrvld;
    logic            wrrdy;
    logic [AW-1:0]   rdaddr;
    logic [WW-1:0]   rddata;
    logic            rdvld;
    logic            rdrdy;
    logic            busy;
    logic            done;
    logic            stray;

    int checks   = 0;
    int failures = 0;

    powlib_ipseqgen #(.ID("IPSEQGEN"), .EDBG(0), .B_BPD(BPD), .B_AW(AW), .LENW(LENW)) dut (
        .clk(clk), .rst(rst),
        .cmdop(cmdop), .cmdaddr(cmdaddr), .cmdlen(cmdlen), .cmddata(cmddata),
        .cmdvld(cmdvld), .cmdrdy(cmdrdy),
        .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
        .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
        .busy(busy), .done(done), .stray(stray)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command end to end; pat gives wrrdy for the first pat_len cycles after accept.
    task automatic do_cmd(input logic [3:0] op, input logic [31:0] addr, input int len,
                          input logic [31:0] data, input int stall_pct, input int rsp_delay,
                          input logic [7:0] pat, input int pat_len, input string name);
        logic [AW-1:0] ea[$];
        logic [WW-1:0] exp_q[$];
        int rsp_due[$];
        int c, last_acc, nth, sent, exp_done;
        bit is_wr, fin;
        is_wr = (op == OP_W);
        for (int k = 0; k <= len; k++) begin
            ea.push_back(addr + 32'(k*BPD));
            if (is_wr) exp_q.push_back({op, 4'hF, data + 32'(k)});
            else       exp_q.push_back({op, 4'hF, data + 32'(k*BPD)});
        end
        chk({name, " cmdrdy idle"}, 64'(cmdrdy), 64'd1);
        cmdop = op; cmdaddr = addr; cmdlen = LENW'(len); cmddata = data; cmdvld = 1'b1;
        tick();
        cmdvld = 1'b0;
        chk({name, " first wrvld"}, 64'(wrvld), 64'd1);
        c = 1; last_acc = -1; nth = -1; sent = 0; fin = 0;
        while (!fin) begin
            exp_done = -1;
            if (ea.size() == 0) begin
                if (is_wr)         exp_done = last_acc + 1;
                else if (nth >= 0) exp_done = ((nth > last_acc) ? nth : last_acc) + 1;
            end
            if (done) begin
                chk({name, " done cycle"}, 64'(c), 64'(exp_done));
                fin = 1;
            end else if (exp_done >= 0 && c > exp_done) begin
                chk({name, " done missing at cycle"}, 64'(c), 64'(exp_done));
                fin = 1;
            end else if (c > 300) begin
                chk({name, " timeout done"}, 64'(done), 64'd1);
                fin = 1;
            end else begin
                chk({name, " busy"}, 64'(busy), 64'd1);
                wrrdy = (c <= pat_len) ? pat[c-1] : ($urandom_range(99) >= 32'(stall_pct));
                if (wrvld) begin
                    if (ea.size() == 0) begin
                        chk({name, " extra beat wrvld"}, 64'(wrvld), 64'd0);
                    end else begin
                        chk({name, " wraddr"}, 64'(wraddr), 64'(ea[0]));
                        chk({name, " wrdata"}, 64'(wrdata), 64'(exp_q[0]));
                        if (wrrdy) begin
                            void'(ea.pop_front());
                            void'(exp_q.pop_front());
                            last_acc = c;
                            if (!is_wr) rsp_due.push_back(c + rsp_delay);
                        end
                    end
                end
                rdvld = 1'b0;
                if (rsp_due.size() > 0 && rsp_due[0] == c) begin
                    void'(rsp_due.pop_front());
                    rdvld  = 1'b1;
                    rdaddr = $urandom;
                    rddata = WW'({$urandom, $urandom});
                    sent++;
                    if (sent == len + 1) nth = c;
                end
                cmdvld  = 1'($urandom_range(1));
                cmdop   = 4'($urandom_range(1));
                cmdaddr = $urandom;
                cmdlen  = LENW'($urandom);
                cmddata = $urandom;
                tick();
                c++;
            end
        end
        cmdvld = 1'b0; rdvld = 1'b0; wrrdy = 1'b0;
        tick();
        chk({name, " done one cycle"}, 64'(done), 64'd0);
        chk({name, " idle busy"}, 64'(busy), 64'd0);
        chk({name, " idle cmdrdy"}, 64'(cmdrdy), 64'd1);
        chk({name, " idle wrvld"}, 64'(wrvld), 64'd0);
    endtask

    initial begin
        rst = 1'b1; cmdop = OP_W; cmdaddr = '0; cmdlen = '0; cmddata = '0; cmdvld = 1'b0;
        wrrdy = 1'b0; rdaddr = '0; rddata = '0; rdvld = 1'b0;
        tick(); tick();
        chk("reset cmdrdy", 64'(cmdrdy), 64'd1);
        chk("reset wrvld",  64'(wrvld),  64'd0);
        chk("reset wraddr", 64'(wraddr), 64'd0);
        chk("reset wrdata", 64'(wrdata), 64'd0);
        chk("reset busy",   64'(busy),   64'd0);
        chk("reset done",   64'(done),   64'd0);
        chk("reset stray",  64'(stray),  64'd0);
        chk("reset rdrdy",  64'(rdrdy),  64'd1);
        rst = 1'b0;
        tick();

        do_cmd(OP_W, 32'h10, 3, 32'hA0, 0, 0, 8'h00, 0, "write4");
        do_cmd(OP_W, 32'h200, 1, 32'h55, 0, 0, 8'b0000_1001, 4, "write_stall");
        do_cmd(OP_R, 32'h0, 2, 32'h100, 0, 3, 8'h00, 0, "read_wait");
        do_cmd(OP_R, 32'h80, 1, 32'h300, 0, 0, 8'b0000_0000, 2, "read_early");
        do_cmd(OP_W, 32'hFFFF_FFFC, 1, 32'h7, 0, 0, 8'h00, 0, "addr_wrap");
        do_cmd(OP_R, 32'hFFFF_FFF8, 3, 32'hFFFF_FFFC, 30, 1, 8'h00, 0, "read_wrap");
        do_cmd(OP_W, 32'h44, 0, 32'hFFFF_FFFF, 0, 0, 8'h00, 0, "write_len0");
        for (int i = 0; i < 10; i++) begin
            do_cmd($urandom_range(1) ? OP_W : OP_R, $urandom, int'($urandom_range(7)), $urandom,
                   int'($urandom_range(60)), int'($urandom_range(4)), 8'h00, 0, "random");
        end
        chk("stray before idle rsp", 64'(stray), 64'd0);

        cmdop = OP_W; cmdaddr = 32'h40; cmdlen = 8'd5; cmddata = 32'h9; cmdvld = 1'b1;
        tick();
        cmdvld = 1'b0; wrrdy = 1'b1;
        tick();
        chk("mid issue wrvld", 64'(wrvld), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; wrrdy = 1'b0;
        chk("abort wrvld",  64'(wrvld),  64'd0);
        chk("abort busy",   64'(busy),   64'd0);
        chk("abort done",   64'(done),   64'd0);
        chk("abort cmdrdy", 64'(cmdrdy), 64'd1);
        chk("abort wraddr", 64'(wraddr), 64'd0);
        tick();
        chk("abort no done", 64'(done), 64'd0);
        chk("stray clear",   64'(stray), 64'd0);
        rdvld = 1'b1;
        tick();
        rdvld = 1'b0;
        chk("stray set", 64'(stray), 64'd1);
        tick(); tick();
        chk("stray sticky", 64'(stray), 64'd1);
        chk("stray idle busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
